// File: rtl/fmult_operand_feeder_if.sv
// Operand stream from the feeder to the floating multiply-accumulate consumer.
// With FMULT_FEEDER_PARITY_EN defined, op_par carries odd parity over {op_idx, op_data}.
interface fmult_operand_feeder_if #(
  parameter int FW = 11
);
  logic          op_valid;
  logic          op_ready;
  logic [FW-1:0] op_data;
  logic [2:0]    op_idx;
  logic          op_last;
`ifdef FMULT_FEEDER_PARITY_EN
  logic          op_par;
`endif

  modport master (
    output op_valid, op_data, op_idx, op_last,
`ifdef FMULT_FEEDER_PARITY_EN
    output op_par,
`endif
    input  op_ready
  );

  modport slave (
    input  op_valid, op_data, op_idx, op_last,
`ifdef FMULT_FEEDER_PARITY_EN
    input  op_par,
`endif
    output op_ready
  );
endinterface

// File: rtl/fmult_operand_feeder.sv
// G.726 predictor operand feeder: DQ/SR float histories streamed as 8 tagged operands.
// Optional FMULT_FEEDER_PARITY_EN adds a registered odd-parity bit on the operand stream.
//
// state  | meaning
// IDLE   | accepting history updates and start
// STREAM | presenting operand idx, waiting for handshakes
// DONE   | one-cycle done pulse, then back to IDLE
module fmult_operand_feeder #(
  parameter int NUM_SR = 2,
  parameter int NUM_DQ = 6,
  parameter int FW     = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    upd_valid,
  input  logic [15:0]             dq,
  input  logic [15:0]             sr,
  input  logic                    start,
  output logic                    idle,
  fmult_operand_feeder_if.master  op,
  output logic                    done,
  input  logic                    scan_in0,
  input  logic                    scan_en,
  output logic                    scan_out0
);

  localparam int         NUM_TAPS = NUM_SR + NUM_DQ;
  localparam logic [2:0] LAST_IDX = 3'(NUM_TAPS - 1);
  localparam logic [FW-1:0] FLOAT_ZERO = 11'h020;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] hist [NUM_TAPS];
  logic [FW-1:0] float_a, float_b, data_nxt, data_q;
  logic [14:0]   sr_mag;
  logic [2:0]    idx_q, idx_nxt;
  logic          last_q, valid_s, hs, upd_en, load;
  logic          unused_scan;

  function automatic logic [10:0] to_float(input logic sgn, input logic [14:0] mag);
    logic [3:0]  e;
    logic [20:0] sh;
    logic [5:0]  m;
    e = '0;
    for (int i = 0; i < 15; i++)
      if (mag[i]) e = 4'(i + 1);
    sh = {mag, 6'b0} >> e;
    m  = (mag == 15'd0) ? 6'd32 : sh[5:0];
    return {sgn, e, m};
  endfunction

  // 0x8000 negates to itself, so its 15-bit magnitude wraps to zero.
  assign sr_mag  = sr[15] ? (~sr[14:0] + 15'd1) : sr[14:0];
  assign float_a = to_float(dq[15], dq[14:0]);
  assign float_b = to_float(sr[15], sr_mag);

  assign upd_en  = (state == S_IDLE) && upd_valid;
  assign hs      = valid_s && op.op_ready;
  assign load    = ((state == S_IDLE) && start) || (hs && (idx_q != LAST_IDX));
  assign idx_nxt = (state == S_IDLE) ? 3'd0 : idx_q + 3'd1;
  // The first operand must reflect an update landing on the same edge as start.
  assign data_nxt = (state == S_IDLE) ? (upd_en ? float_b : hist[0]) : hist[idx_nxt];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) hist[i] <= FLOAT_ZERO;
    end else if (upd_en) begin
      for (int i = 1; i < NUM_SR; i++) hist[i] <= hist[i-1];
      hist[0] <= float_b;
      for (int i = NUM_SR + 1; i < NUM_TAPS; i++) hist[i] <= hist[i-1];
      hist[NUM_SR] <= float_a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_STREAM;
      S_STREAM: if (hs && (idx_q == LAST_IDX)) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idle    = (state == S_IDLE);
    valid_s = (state == S_STREAM);
    done    = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= 3'd0;
      data_q <= FLOAT_ZERO;
      last_q <= 1'b0;
    end else if (load) begin
      idx_q  <= idx_nxt;
      data_q <= data_nxt;
      last_q <= (idx_nxt == LAST_IDX);
    end
  end

`ifdef FMULT_FEEDER_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     par_q <= 1'b0;
    else if (load) par_q <= ~^{idx_nxt, data_nxt};
  end
  assign op.op_par = par_q;
`endif

  assign op.op_valid = valid_s;
  assign op.op_data  = data_q;
  assign op.op_idx   = idx_q;
  assign op.op_last  = last_q;

  assign unused_scan = ^{scan_in0, scan_en};
  assign scan_out0   = 1'b0;

endmodule

// File: tb/tb_fmult_operand_feeder.sv
// Scoreboard bench for fmult_operand_feeder: directed updates/streams with hand-computed floats.
module tb_fmult_operand_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid, start;
  logic [15:0] dq, sr;
  logic        idle, done, scan_out0;
  logic        scan_in0 = 1'b0, scan_en = 1'b0;

  fmult_operand_feeder_if bus ();

  fmult_operand_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .upd_valid (upd_valid),
    .dq        (dq),
    .sr        (sr),
    .start     (start),
    .idle      (idle),
    .op        (bus),
    .done      (done),
    .scan_in0  (scan_in0),
    .scan_en   (scan_en),
    .scan_out0 (scan_out0)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [14:0] sbq [$];
  logic [10:0] eh [8];
  bit prev_last_hs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) eh[i] = 11'h020;
  endtask

  task automatic model_update(input logic [10:0] fa, input logic [10:0] fb);
    eh[1] = eh[0];
    eh[0] = fb;
    for (int i = 7; i > 2; i--) eh[i] = eh[i-1];
    eh[2] = fa;
  endtask

  // Monitor: pops expected words on each handshake and checks done timing.
  always @(negedge clk) begin
    if (reset) begin
      prev_last_hs = 1'b0;
    end else begin
      if (done) chk("done_after_last", 32'(prev_last_hs), 32'd1);
      if (bus.op_valid && bus.op_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_word", {18'd0, bus.op_last, bus.op_idx, bus.op_data}, 32'h7fff);
        end else begin
          logic [14:0] e;
          e = sbq.pop_front();
          chk("op_word", {17'd0, bus.op_last, bus.op_idx, bus.op_data}, {17'd0, e});
`ifdef FMULT_FEEDER_PARITY_EN
          chk("op_par", 32'(bus.op_par), 32'(~^e[13:0]));
`endif
        end
      end
      prev_last_hs = bus.op_valid && bus.op_ready && bus.op_last;
    end
  end

  task automatic do_update(input logic [15:0] d, input logic [15:0] s,
                           input logic [10:0] fa, input logic [10:0] fb);
    upd_valid = 1'b1; dq = d; sr = s;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    model_update(fa, fb);
  endtask

  task automatic run_stream(input bit do_upd, input logic [15:0] d, input logic [15:0] s,
                            input logic [10:0] fa, input logic [10:0] fb,
                            input int stall_idx, input bit cmd_during, input int abort_idx);
    int cycles, stalls;
    bit stalled;
    logic [10:0] hd;
    logic [2:0]  hi;
    if (do_upd) model_update(fa, fb);
    for (int i = 0; i < 8; i++)
      if (abort_idx < 0 || i < abort_idx) sbq.push_back({(i == 7), 3'(i), eh[i]});
    start = 1'b1; upd_valid = do_upd; dq = d; sr = s; bus.op_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; upd_valid = 1'b0;
    chk("first_valid_latency", 32'(bus.op_valid), 32'd1);
    cycles = 0; stalls = 0;
    while (!done && cycles < 64) begin
      if (abort_idx >= 0 && bus.op_idx == 3'(abort_idx)) begin
        #1 reset = 1'b1;
        #1;
        chk("abort_valid", 32'(bus.op_valid), 32'd0);
        chk("abort_idle", 32'(idle), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_queue_empty", 32'(sbq.size()), 32'd0);
        sbq.delete();
        return;
      end
      stalled = (bus.op_idx == 3'(stall_idx)) && (stalls < 3);
      if (stalled) stalls++;
      bus.op_ready = !stalled;
      if (cmd_during && bus.op_idx == 3'd2) begin
        upd_valid = 1'b1; start = 1'b1; dq = 16'h1234; sr = 16'h1234;
      end
      hd = bus.op_data; hi = bus.op_idx;
      @(posedge clk); #1;
      upd_valid = 1'b0; start = 1'b0;
      if (stalled) begin
        chk("hold_valid", 32'(bus.op_valid), 32'd1);
        chk("hold_idx", 32'(bus.op_idx), 32'(hi));
        chk("hold_data", 32'(bus.op_data), 32'(hd));
      end
      cycles++;
    end
    bus.op_ready = 1'b1;
    chk("done_seen", 32'(done), 32'd1);
    chk("stream_cycles", 32'(cycles), 32'(8 + stalls));
    @(posedge clk); #1;
    chk("idle_after_done", 32'(idle), 32'd1);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("queue_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    reset = 1'b1; upd_valid = 1'b0; start = 1'b0; dq = '0; sr = '0;
    bus.op_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_last", 32'(bus.op_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(bus.op_idx), 32'd0);
    chk("rst_data", 32'(bus.op_data), 32'h020);
    chk("scan_out0", 32'(scan_out0), 32'd0);
`ifdef FMULT_FEEDER_PARITY_EN
    chk("rst_par", 32'(bus.op_par), 32'd0);
`endif
    @(posedge clk); #1;

    run_stream(1'b0, 16'h0, 16'h0, 11'h0, 11'h0, -1, 1'b0, -1);

    do_update(16'h0005, 16'hFFFB, 11'h0E8, 11'h4E8);
    run_stream(1'b0, 16'h0, 16'h0, 11'h0, 11'h0, -1, 1'b0, -1);

    do_update(16'h7FFF, 16'h8000, 11'h3FF, 11'h420);
    do_update(16'h8000, 16'h0000, 11'h420, 11'h020);
    run_stream(1'b0, 16'h0, 16'h0, 11'h0, 11'h0, 4, 1'b0, -1);

    run_stream(1'b0, 16'h0, 16'h0, 11'h0, 11'h0, -1, 1'b1, -1);
    run_stream(1'b0, 16'h0, 16'h0, 11'h0, 11'h0, -1, 1'b0, -1);

    run_stream(1'b1, 16'h0001, 16'h0001, 11'h060, 11'h060, -1, 1'b0, -1);

    run_stream(1'b0, 16'h0, 16'h0, 11'h0, 11'h0, -1, 1'b0, 3);
    @(posedge clk); #1;
    run_stream(1'b0, 16'h0, 16'h0, 11'h0, 11'h0, -1, 1'b0, -1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fmult_operand_feeder.md
Name: fmult_operand_feeder

Overview:
Producer side of the ADPCM predictor floating-multiply datapath. It converts each new quantized difference DQ and reconstructed signal SR into the 11-bit G.726 float format (FLOATA/FLOATB) and keeps them in shift-register histories. On command it streams the 8 history operands, with index tags, to the floating multiply-accumulate consumer over a valid/ready handshake.

Parameters:
NUM_SR, 2, SR history depth (pole taps A1..A2); fixed at 2 for G.726.
NUM_DQ, 6, DQ history depth (zero taps B1..B6); fixed at 6 for G.726.
FW, 11, float word width: sign[10], exp[9:6], mant[5:0].

Ports:
clk  input  1  system clock
reset  input  1  system reset; asynchronous, active-high
upd_valid  input  1  strobe: push new dq/sr into the histories
dq  input  16  quantized difference, sign-magnitude (bit15 sign, [14:0] magnitude)
sr  input  16  reconstructed signal, two's complement
start  input  1  strobe: begin streaming the current histories
idle  output  1  high in IDLE; upd_valid/start are honoured only while high
op_valid  output  1  operand word valid
op_ready  input  1  consumer accepts operand
op_data  output  11  float operand
op_idx  output  3  tap index 0..7 (0=SR1, 1=SR2, 2..7=DQ1..DQ6)
op_last  output  1  high with op_idx==7
done  output  1  one-cycle pulse after the last operand is accepted
scan_in0  input  1  test scan data in; no functional effect
scan_en  input  1  test scan enable; no functional effect
scan_out0  output  1  test scan data out; tie 0 in RTL

Behaviour:
- Float conversion (combinational, registered on update):
  - EXP = bit length of MAG (0..15).
  - MANT = (MAG==0) ? 32 : (MAG<<6)>>EXP.
  - word = {sign, EXP[3:0], MANT[5:0]}.
- FLOATA (dq): sign=dq[15], MAG=dq[14:0].
- FLOATB (sr): sign=sr[15], MAG = sign ? (-sr)&0x7FFF : sr[14:0]. For sr=0x8000 the result is MAG=0, word 0x420.
- Reset state: all history entries 0x020 (+0 float). State IDLE. idle=1, op_valid=0, op_last=0, done=0, op_idx=0, op_data=0x020.
- Update, on a clk edge with idle=1 and upd_valid=1:
  - SR2<=SR1, SR1<=FLOATB(sr).
  - DQ6<=DQ5 ... DQ2<=DQ1, DQ1<=FLOATA(dq).
  - upd_valid while idle=0 is ignored; histories are unchanged.
- FSM:
  - IDLE --start--> STREAM, with idx=0 and op_valid=1 on the next cycle. start while not IDLE is ignored.
  - STREAM: op_data/op_idx/op_last are registered and stay stable while op_valid=1 and op_ready=0.
  - STREAM, on handshake (op_valid & op_ready) with idx<7: idx+1 next cycle. There are no bubbles under continuous op_ready.
  - STREAM, on handshake with idx==7: go to DONE, op_valid=0.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - Latency: start edge to first op_valid is 1 cycle. Full stream with op_ready tied high is 8 cycles. done is asserted on the cycle after the last handshake.
- upd_valid and start in the same IDLE cycle: the update is applied at that edge, and the stream carries the updated histories.
- op_ready may be high while op_valid=0; this has no effect.
- Reset asserted mid-stream: asynchronous return to IDLE, histories re-initialised to 0x020, op_valid and done drop immediately.

Optional Feature:
FMULT_FEEDER_PARITY_EN
- Defined: adds output op_par (1 bit) = odd parity over {op_idx, op_data}. It is registered with op_data and held stable under backpressure. Reset value is the parity of {0, 0x020}, which is 0.
- Undefined: the op_par port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then start with op_ready=1 -> 8 words 0x020, op_idx 0..7, op_last only on idx 7, done pulses 1 cycle after idx 7.
- upd dq=0x0005, sr=0xFFFB, then start -> idx0=0x4E8, idx1=0x020, idx2=0x0E8, idx3..7=0x020.
- Boundaries: upd dq=0x7FFF, sr=0x8000 -> DQ1=0x3FF, SR1=0x420. Then upd dq=0x8000, sr=0x0000 -> DQ1=0x420, DQ2=0x3FF, SR1=0x020, SR2=0x420.
- Backpressure: op_ready=0 for 3 cycles while idx=4 -> op_valid held, op_data/op_idx stable. The stream completes with no skipped or duplicated idx.
- Ignored commands: upd_valid and start during STREAM -> histories unchanged, no restart. upd_valid and start together in IDLE -> the stream shows the new values.
- Reset pulsed at idx=3 -> op_valid=0 asynchronously, idle=1, and a following start streams all 0x020.
